// File: rtl/arbiter_pkg.sv
// Shared types and sizing for the square arbiter: FSM state encoding and
// board geometry constants.
package arbiter_pkg;

    localparam int unsigned PRIO_W      = 3;
    localparam int unsigned SQ_W        = 6;
    localparam int unsigned NUM_SQUARES = 64;
    localparam int unsigned GROUP_SIZE  = 8;
    localparam int unsigned NUM_GROUPS  = NUM_SQUARES / GROUP_SIZE;

    localparam logic [PRIO_W-1:0] PRIO_NONE = '0;

    typedef enum logic [1:0] {
        IDLE,
        RED1,
        RED2,
        DONE
    } state_t;

endpackage

// File: rtl/prio_max8.sv
// Combinational 8-way priority maximum; entries are supplied in ascending
// index order so a strict compare keeps the lowest index on ties.
module prio_max8
    import arbiter_pkg::*;
(
    input  logic [GROUP_SIZE*PRIO_W-1:0] i_prio,
    input  logic [GROUP_SIZE*SQ_W-1:0]   i_idx,
    output logic [PRIO_W-1:0]            o_prio,
    output logic [SQ_W-1:0]              o_idx
);

    always_comb begin
        o_prio = i_prio[PRIO_W-1:0];
        o_idx  = i_idx[SQ_W-1:0];
        for (int unsigned k = 1; k < GROUP_SIZE; k++) begin
            if (i_prio[k*PRIO_W +: PRIO_W] > o_prio) begin
                o_prio = i_prio[k*PRIO_W +: PRIO_W];
                o_idx  = i_idx[k*SQ_W +: SQ_W];
            end
        end
    end

endmodule

// File: rtl/square_arbiter.sv
// Two-stage board arbiter: snapshot on start, 64->8 in RED1, 8->1 in RED2.
// Optional king-attacked tracking is enabled by defining SQUARE_ARBITER_KING_EN.
module square_arbiter
    import arbiter_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_SQUARES*PRIO_W-1:0] prio_bus,
    input  logic [NUM_SQUARES-1:0]        king_bus,
    output logic                          busy,
    output logic                          done,
    output logic [SQ_W-1:0]               sel_square,
    output logic [PRIO_W-1:0]             sel_prio,
    output logic                          sel_valid,
    output logic                          king_seen
);

    state_t                          r_state;
    logic                            r_busy;
    logic                            r_done;
    logic [NUM_SQUARES*PRIO_W-1:0]   r_snap_prio;
    logic [NUM_GROUPS*PRIO_W-1:0]    r_grp_prio;
    logic [NUM_GROUPS*SQ_W-1:0]      r_grp_idx;
    logic [SQ_W-1:0]                 r_sel_square;
    logic [PRIO_W-1:0]               r_sel_prio;
    logic                            r_sel_valid;

    logic [NUM_GROUPS*PRIO_W-1:0]    w_grp_prio;
    logic [NUM_GROUPS*SQ_W-1:0]      w_grp_idx;
    logic [PRIO_W-1:0]               w_fin_prio;
    logic [SQ_W-1:0]                 w_fin_idx;

`ifdef SQUARE_ARBITER_KING_EN
    logic [NUM_SQUARES-1:0]          r_snap_king;
    logic                            r_king_seen;
    assign king_seen = r_king_seen;
`else
    logic                            w_unused_king;
    assign w_unused_king = ^king_bus;
    assign king_seen     = 1'b0;
`endif

    assign busy       = r_busy;
    assign done       = r_done;
    assign sel_square = r_sel_square;
    assign sel_prio   = r_sel_prio;
    assign sel_valid  = r_sel_valid;

    // Stage 1: each group carries its own absolute square indices.
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        logic [GROUP_SIZE*SQ_W-1:0] w_idx;
        for (genvar k = 0; k < GROUP_SIZE; k++) begin : g_idx
            assign w_idx[k*SQ_W +: SQ_W] = SQ_W'(g*GROUP_SIZE + k);
        end
        prio_max8 u_grp (
            .i_prio (r_snap_prio[g*GROUP_SIZE*PRIO_W +: GROUP_SIZE*PRIO_W]),
            .i_idx  (w_idx),
            .o_prio (w_grp_prio[g*PRIO_W +: PRIO_W]),
            .o_idx  (w_grp_idx[g*SQ_W +: SQ_W])
        );
    end

    // Stage 2: group 0 wins an all-zero board, yielding index 0.
    prio_max8 u_final (
        .i_prio (r_grp_prio),
        .i_idx  (r_grp_idx),
        .o_prio (w_fin_prio),
        .o_idx  (w_fin_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_snap_prio  <= '0;
            r_grp_prio   <= '0;
            r_grp_idx    <= '0;
            r_sel_square <= '0;
            r_sel_prio   <= '0;
            r_sel_valid  <= 1'b0;
`ifdef SQUARE_ARBITER_KING_EN
            r_snap_king  <= '0;
            r_king_seen  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_snap_prio <= prio_bus;
`ifdef SQUARE_ARBITER_KING_EN
                        r_snap_king <= king_bus;
`endif
                        r_state     <= RED1;
                        r_busy      <= 1'b1;
                    end
                end
                RED1: begin
                    r_grp_prio <= w_grp_prio;
                    r_grp_idx  <= w_grp_idx;
                    r_state    <= RED2;
                end
                RED2: begin
                    r_sel_square <= w_fin_idx;
                    r_sel_prio   <= w_fin_prio;
                    r_sel_valid  <= (w_fin_prio != PRIO_NONE);
`ifdef SQUARE_ARBITER_KING_EN
                    r_king_seen  <= |r_snap_king;
`endif
                    r_done       <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
